aes_lite_sched: RTL and testbench

//  Round-robin scheduler sharing one AES-lite byte round engine between NUM_REQ requesters.

---
 rtl/aes_lite_sched.sv | 125 ++++++++++++
 tb/tb_aes_lite_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_lite_sched.sv
// aes_lite_sched: round-robin scheduler sharing one byte round engine
// between NUM_REQ requesters; each job runs NUM_ROUNDS rounds of
// state ^= key ^ round_idx and returns the result tagged with its id.
// Ports: clk, rst_n (async active-low), req_valid/req_data/req_key in,
// req_ready out (one-hot), rsp_valid/rsp_data/rsp_id out, rsp_ready in,
// busy out (ROUND or DONE).
// Config: define AES_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration.
module aes_lite_sched #(
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_ROUNDS = 10,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [8*NUM_REQ-1:0] req_key,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      key_q, key_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;

  // Scan from the highest offset down so the lowest offset from
  // rr_ptr_q wins. With fixed priority rr_ptr_q stays 0, which
  // turns the same scan into lowest-index-wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    key_d     = key_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          // Gate on rst_n so a held request never sees ready in reset.
          req_ready[grant_id] = rst_n;
          data_d  = req_data[{grant_id, 3'b000} +: 8];
          key_d   = req_key[{grant_id, 3'b000} +: 8];
          id_d    = grant_id;
          cnt_d   = '0;
          state_d = ROUND;
`ifdef AES_SCHED_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = ID_W'((int'(grant_id) + 1) % NUM_REQ);
`endif
        end
      end
      ROUND: begin
        data_d = data_q ^ key_q ^ {4'b0000, cnt_q};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      key_q    <= key_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_lite_sched.sv
// tb_aes_lite_sched: directed + randomized checks of aes_lite_sched
// against a closed-form result model and a grant-order model.
module tb_aes_lite_sched;

  localparam int NQ = 4;
  localparam int NR = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NQ-1:0]   req_valid = '0;
  logic [8*NQ-1:0] req_data = '0;
  logic [8*NQ-1:0] req_key = '0;
  logic [NQ-1:0]   req_ready;
  logic            rsp_valid;
  logic [7:0]      rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_ready = 1'b0;
  logic            busy;

  logic [1:0]      v3 = '0;
  logic [15:0]     d3 = '0;
  logic [15:0]     k3 = '0;
  logic [1:0]      rdy3;
  logic            rv3;
  logic [7:0]      rd3;
  logic [0:0]      rid3;
  logic            rr3 = 1'b0;
  logic            busy3;

  aes_lite_sched #(.NUM_REQ(NQ), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_key(req_key),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  aes_lite_sched #(.NUM_REQ(2), .NUM_ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_data(d3), .req_key(k3),
    .req_ready(rdy3),
    .rsp_valid(rv3), .rsp_data(rd3), .rsp_id(rid3),
    .rsp_ready(rr3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int rr = 0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // data ^ (odd rounds ? key : 0) ^ XOR of all round indices
  function automatic logic [7:0] model(input logic [7:0] d,
                                       input logic [7:0] k,
                                       input int nr);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < nr; i++) x ^= 8'(i);
    return d ^ ((nr % 2 == 1) ? k : 8'h00) ^ x;
  endfunction

  function automatic int pick(input logic [NQ-1:0] m);
    int s;
`ifdef AES_SCHED_FIXED_PRIO_EN
    s = 0;
`else
    s = rr;
`endif
    for (int i = 0; i < NQ; i++)
      if (m[(s + i) % NQ]) return (s + i) % NQ;
    return -1;
  endfunction

  task automatic run_job(input logic [NQ-1:0] m, input int bp,
                         input logic [8*NQ-1:0] d,
                         input logic [8*NQ-1:0] k);
    int g;
    logic [7:0] ex;
    req_valid = m;
    req_data  = d;
    req_key   = k;
    rsp_ready = (bp == 0);
    #1;
    g  = pick(m);
    ex = model(d[8*g +: 8], k[8*g +: 8], NR);
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
`ifndef AES_SCHED_FIXED_PRIO_EN
    rr = (g + 1) % NQ;
`endif
    for (int c = 1; c <= NR; c++) begin
      chk("round_rsp_valid", 32'(rsp_valid), 0);
      chk("round_busy", 32'(busy), 1);
      chk("round_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    for (int c = 0; c < bp; c++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 32'(ex));
      chk("bp_id", 32'(rsp_id), 32'(g));
      chk("bp_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_data", 32'(rsp_data), 32'(ex));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_idle_busy", 32'(busy), 0);
    chk("post_idle_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    int g;
    logic [NQ-1:0] m;
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("idle_noreq_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("idle_noreq_busy", 32'(busy), 0);

    for (int j = 0; j < 5; j++)
      run_job(4'b1111, 0, $urandom, $urandom);

    run_job(4'b0001, 0, 32'h0000_003C, 32'h0000_00A5);
    chk("single_model", 32'(model(8'h3C, 8'hA5, NR)), 32'h3D);

    run_job(4'b1110, 20, $urandom, $urandom);

    for (int j = 0; j < 20; j++) begin
      m = 4'($urandom_range(1, 15));
      run_job(m, int'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // reset while a job is in its rounds
    req_valid = 4'b0010;
    req_data  = 32'h0000_7700;
    req_key   = 32'h0000_1100;
    #1;
    g = pick(4'b0010);
    chk("mid_grant", 32'(req_ready), 32'(1 << g));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    rr = 0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_data", 32'(rsp_data), 0);
    chk("mid_rst_id", 32'(rsp_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_hold_valid", 32'(rsp_valid), 0);
    end
    rst_n = 1'b1;
    run_job(4'b0100, 0, $urandom, $urandom);

    // three-round instance, odd round count keeps the key
    v3  = 2'b01;
    d3  = 16'h0010;
    k3  = 16'h000F;
    rr3 = 1'b1;
    #1;
    chk("r3_grant", 32'(rdy3), 32'h1);
    @(posedge clk); #1;
    v3 = '0;
    for (int c = 1; c <= 3; c++) begin
      chk("r3_round_valid", 32'(rv3), 0);
      @(posedge clk); #1;
    end
    chk("r3_valid", 32'(rv3), 1);
    chk("r3_data", 32'(rd3), 32'h1C);
    chk("r3_id", 32'(rid3), 0);
    @(posedge clk); #1;
    chk("r3_idle", 32'(busy3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
